// File: rtl/div_sched.sv
// div_sched: sequencing controller for the multi-cycle signed divider.
// Latches a divide request, screens out divide-by-zero, pulses the divider
// start, counts its iterations and captures HI/LO into stable result
// registers. Raises busy (pipeline stall) while an operation is in flight and
// aborts cleanly on flush.
//
// Optional feature macro: DIV_SCHED_EARLY_EN
//   When defined, a divide with |numerator| < |denominator| bypasses the
//   divider (lo=0, hi=numerator). The magnitude compare is registered, so
//   CHECK takes two cycles for nonzero divisors in that build.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   req, flush          request (level, held until ack), abort
//   srcA, srcB          numerator / denominator (two's complement)
//   ack                 one-cycle pulse, request accepted
//   busy                pipeline stall while an operation is in flight
//   div_start, div_clr  divider start pulse / divider synchronous clear
//   div_a, div_b        latched operands to the divider
//   div_hi, div_lo      divider remainder / quotient
//   hi, lo              registered remainder / quotient results
//   done, div_zero      completion pulse / divide-by-zero pulse
module div_sched #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             flush,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             ack,
    output logic             busy,
    output logic             div_start,
    output logic             div_clr,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_START,
        S_RUN,
        S_CAPTURE,
        S_ZERO
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             accept_c;
    logic             abort_c;

`ifdef DIV_SCHED_EARLY_EN
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic             early_lt;
    logic             chk_seen;
    logic             bypass;

    // Unsigned magnitudes; the most negative value maps to itself, which is correct as unsigned.
    assign mag_a_c = div_a[WIDTH-1] ? (~div_a + WIDTH'(1)) : div_a;
    assign mag_b_c = div_b[WIDTH-1] ? (~div_b + WIDTH'(1)) : div_b;

    // Registered compare keeps the negate+compare path out of the next-state logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            early_lt <= 1'b0;
            chk_seen <= 1'b0;
            bypass   <= 1'b0;
        end else begin
            early_lt <= (mag_a_c < mag_b_c);
            chk_seen <= (state == S_CHECK) && (state_d == S_CHECK);
            if ((state_d == S_CAPTURE) && (state != S_CAPTURE)) begin
                bypass <= (state == S_CHECK);
            end
        end
    end
`endif

    // Next state and iteration counter.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        accept_c = (state == S_IDLE) && req && !flush;
        abort_c  = (state != S_IDLE) && flush;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (accept_c) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (div_b == '0) begin
                    state_d = S_ZERO;
                end
`ifdef DIV_SCHED_EARLY_EN
                else if (!chk_seen) begin
                    state_d = S_CHECK;
                end else if (early_lt) begin
                    state_d = S_CAPTURE;
                end
`endif
                else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // The start cycle is iteration 1.
                cnt_d   = CNT_W'(1);
                state_d = (DIV_CYCLES > 1) ? S_RUN : S_CAPTURE;
            end
            S_RUN: begin
                if (cnt < CNT_LAST) begin
                    cnt_d = cnt + CNT_W'(1);
                end
                if (cnt >= CNT_LAST - CNT_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_IDLE;
            S_ZERO:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Flush overrides every transition.
        if (abort_c) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            div_start <= 1'b0;
            div_clr   <= 1'b1;
            div_a     <= '0;
            div_b     <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ack       <= accept_c;
            // Low in the ack cycle and from the edge at which done rises.
            busy      <= (state != S_IDLE) && (state_d != S_IDLE);
            div_start <= (state_d == S_START);
            div_clr   <= abort_c;
            done      <= !abort_c && ((state == S_CAPTURE) || (state == S_ZERO));
            div_zero  <= !abort_c && (state == S_ZERO);
            if (accept_c) begin
                div_a <= srcA;
                div_b <= srcB;
            end
            if (!abort_c && (state == S_CAPTURE)) begin
`ifdef DIV_SCHED_EARLY_EN
                hi <= bypass ? div_a : div_hi;
                lo <= bypass ? '0 : div_lo;
`else
                hi <= div_hi;
                lo <= div_lo;
`endif
            end
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Testbench for div_sched: behavioural divider, table-driven vectors,
// hand-written flush / held-request / mid-run reset sequences, random ops.
module tb_div_sched;

    localparam int unsigned W  = 32;
    localparam int          DC = 32;
`ifdef DIV_SCHED_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          req;
    logic          flush;
    logic [W-1:0]  srcA;
    logic [W-1:0]  srcB;
    logic          ack;
    logic          busy;
    logic          div_start;
    logic          div_clr;
    logic [W-1:0]  div_a;
    logic [W-1:0]  div_b;
    logic [W-1:0]  div_hi;
    logic [W-1:0]  div_lo;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          done;
    logic          div_zero;

    div_sched #(.WIDTH(W), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .srcA(srcA), .srcB(srcB), .ack(ack), .busy(busy),
        .div_start(div_start), .div_clr(div_clr),
        .div_a(div_a), .div_b(div_b), .div_hi(div_hi), .div_lo(div_lo),
        .hi(hi), .lo(lo), .done(done), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: loads on div_start, result valid DC-1 edges later.
    logic signed [W-1:0] dv_a;
    logic signed [W-1:0] dv_b;
    int                  dv_cnt;
    always @(posedge clk) begin
        if (div_clr) begin
            dv_cnt <= 0;
            div_hi <= 32'hDEAD_BEEF;
            div_lo <= 32'hDEAD_BEEF;
        end else if (div_start) begin
            dv_a   <= div_a;
            dv_b   <= div_b;
            dv_cnt <= 1;
            div_hi <= 32'hDEAD_BEEF;
            div_lo <= 32'hDEAD_BEEF;
        end else if (dv_cnt != 0 && dv_cnt < DC) begin
            dv_cnt <= dv_cnt + 1;
            if (dv_cnt + 1 == DC) begin
                div_lo <= dv_a / dv_b;
                div_hi <= dv_a % dv_b;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_lo = '0;
    logic [W-1:0] prev_hi = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? 32'(-v) : v;
    endfunction

    // Edges after the accepting edge at which done rises.
    function automatic int exp_edge(input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 2;
        if (EARLY) return (mag(a) < mag(b)) ? 3 : DC + 3;
        return DC + 2;
    endfunction

    function automatic bit exp_started(input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1'b0;
        if (EARLY && (mag(a) < mag(b))) return 1'b0;
        return 1'b1;
    endfunction

    // One complete request; starts and ends at a negedge with the DUT idle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_lo, input logic [31:0] e_hi,
                          input bit e_zero, input string tag);
        int ek;
        int done_k;
        int start_k;
        int start_n;
        int done_n;
        int zero_n;
        int busy_bad;
        int stab_bad;
        logic [31:0] hi_s;
        logic [31:0] lo_s;
        bit st;
        ek = exp_edge(a, b);
        st = exp_started(a, b);
        done_k = -1; start_k = -1; start_n = 0; done_n = 0; zero_n = 0;
        busy_bad = 0; stab_bad = 0; hi_s = '0; lo_s = '0;
        req = 1'b1; srcA = a; srcB = b;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".ack"}, 32'(ack), 32'd1);
        chk({tag, ".busy0"}, 32'(busy), 32'd0);
        req = 1'b0; srcA = $urandom; srcB = $urandom;
        for (int k = 1; k <= DC + 8; k++) begin
            @(negedge clk);
            if (div_start) begin
                start_n++;
                if (start_k < 0) start_k = k;
            end
            if (done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k; hi_s = hi; lo_s = lo;
                end
            end
            if (div_zero) zero_n++;
            if (busy !== (done_k < 0)) busy_bad++;
            if (done_k < 0 && (div_a !== a || div_b !== b)) stab_bad++;
            if (done_k >= 0 && k == done_k + 1) break;
        end
        chk({tag, ".done_edge"}, 32'(done_k), 32'(ek));
        chk({tag, ".done_n"}, 32'(done_n), 32'd1);
        chk({tag, ".zero_n"}, 32'(zero_n), 32'(e_zero));
        chk({tag, ".start_n"}, 32'(start_n), 32'(st));
        chk({tag, ".start_edge"}, 32'(start_k), st ? 32'(EARLY ? 2 : 1) : 32'hFFFF_FFFF);
        chk({tag, ".lo"}, lo_s, e_lo);
        chk({tag, ".hi"}, hi_s, e_hi);
        chk({tag, ".busy"}, 32'(busy_bad), 32'd0);
        chk({tag, ".opnd_stable"}, 32'(stab_bad), 32'd0);
        prev_lo = e_lo;
        prev_hi = e_hi;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, ".ack"}, 32'(ack), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".start"}, 32'(div_start), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".zero"}, 32'(div_zero), 32'd0);
        chk({tag, ".clr"}, 32'(div_clr), 32'd1);
        chk({tag, ".hi"}, hi, 32'd0);
        chk({tag, ".lo"}, lo, 32'd0);
        chk({tag, ".div_a"}, div_a, 32'd0);
        chk({tag, ".div_b"}, div_b, 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        bit          zero;
    } vec_t;

    vec_t tab[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_ack, first_ack, second_ack, overlap, n_done, n_clr, n_bad;
        logic [31:0] ra;
        logic [31:0] rb;
        logic signed [31:0] sa;
        logic signed [31:0] sb;

        tab[0] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        tab[1] = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
        tab[2] = '{32'd7,         32'd0,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b1};
        tab[3] = '{32'd3,         32'd10,        32'd0,         32'd3,         1'b0};
        tab[4] = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
        tab[5] = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
        tab[6] = '{32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
        tab[7] = '{32'd0,         32'd0,         32'hFFFFFFFD,  32'd1,         1'b1};
        tab[8] = '{32'h80000000,  32'd2,         32'hC0000000,  32'd0,         1'b0};
        tab[9] = '{32'h7FFFFFFF,  32'hFFFFFFFF,  32'h80000001,  32'd0,         1'b0};

        reset = 1'b0; req = 1'b0; flush = 1'b0; srcA = '0; srcB = '0;
        repeat (2) @(negedge clk);
        reset_vals("por");
        reset = 1'b1;
        @(negedge clk);
        chk("por.clr_release", 32'(div_clr), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(tab[i].a, tab[i].b, tab[i].lo, tab[i].hi, tab[i].zero, $sformatf("vec%0d", i));
        end

        // Flush ten cycles into RUN of 50/5.
        req = 1'b1; srcA = 32'd50; srcB = 32'd5;
        @(posedge clk);
        @(negedge clk);
        chk("flush.ack", 32'(ack), 32'd1);
        req = 1'b0;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush.clr", 32'(div_clr), 32'd1);
        chk("flush.busy", 32'(busy), 32'd0);
        n_clr = 0; n_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (div_clr) n_clr++;
            if (done || div_zero || div_start || busy || ack) n_bad++;
        end
        chk("flush.clr_single", 32'(n_clr), 32'd0);
        chk("flush.quiet", 32'(n_bad), 32'd0);
        chk("flush.lo_kept", lo, prev_lo);
        chk("flush.hi_kept", hi, prev_hi);
        run_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, "post_flush");

        // req held high through a full operation.
        req = 1'b1; srcA = 32'd100; srcB = 32'd7;
        n_ack = 0; first_ack = -1; second_ack = -1; overlap = 0; n_done = 0;
        for (int k = 0; k < 2 * (DC + 6); k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) begin
                n_ack++;
                if (first_ack < 0) first_ack = k;
                else if (second_ack < 0) begin
                    second_ack = k;
                    req = 1'b0;
                end
            end
            if (ack && busy) overlap++;
            if (done) n_done++;
        end
        req = 1'b0;
        chk("held.acks", 32'(n_ack), 32'd2);
        chk("held.gap", 32'(second_ack - first_ack), 32'(exp_edge(32'd100, 32'd7) + 1));
        chk("held.overlap", 32'(overlap), 32'd0);
        chk("held.dones", 32'(n_done), 32'd2);
        chk("held.lo", lo, 32'd14);
        chk("held.hi", hi, 32'd2);

        // Reset during RUN.
        req = 1'b1; srcA = 32'd100; srcB = 32'd7;
        @(posedge clk);
        @(negedge clk);
        chk("rst.ack", 32'(ack), 32'd1);
        req = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        reset_vals("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst.clr_hold", 32'(div_clr), 32'd1);
        @(negedge clk);
        chk("rst.clr_release", 32'(div_clr), 32'd0);
        run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "post_rst");

        // Random operations against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] e_lo;
            logic [31:0] e_hi;
            bit z;
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin
                    ra = 32'($urandom_range(0, 40)) - 32'd20;
                    rb = 32'($urandom_range(21, 200));
                    if ($urandom_range(0, 1) == 1) rb = 32'(-rb);
                end
                2: begin
                    rb = 32'($urandom_range(1, 9));
                    if ($urandom_range(0, 1) == 1) rb = 32'(-rb);
                end
                default: ;
            endcase
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            z = (rb == 0);
            if (z) begin
                e_lo = prev_lo; e_hi = prev_hi;
            end else begin
                sa = ra; sb = rb;
                e_lo = 32'(sa / sb);
                e_hi = 32'(sa % sb);
            end
            run_op(ra, rb, e_lo, e_hi, z, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
